// File: rtl/pc_seq_ctrl.sv
// Purpose : program-counter sequencer; holds the fetch PC and drives fetch requests
//           over a valid/ready handshake, applying trap > redirect > accept > stall/halt.
// Latency : all outputs registered; a request appears the cycle after IDLE sees !stall.
// Backpressure: a raised request holds valid/addr until accepted, trapped or redirected;
//           stall only blocks new requests, it never withdraws a pending one.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   stall, halt_req, resume          flow control / halt entry and exit
//   redirect_valid, redirect_target  branch/jump load of the PC
//   trap_req                         trap entry (PC -> TRAP_VECTOR, PC saved in epc)
//   fetch_ready / fetch_valid        instruction-fetch handshake
//   fetch_addr                       current PC (request address)
//   fetch_flush                      one-cycle pulse after trap/redirect
//   epc, halted, fetch_cnt           trap PC, halt status, accepted-request count
//   misalign                         one-cycle pulse on misaligned redirect
//
// Build option: define PC_ALIGN_CHECK_EN to turn misaligned redirect targets into traps;
// without it the low two target bits are cleared and misalign is tied low.
module pc_seq_ctrl #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_req,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  fetch_addr,
    output logic             fetch_flush,
    output logic [XLEN-1:0]  epc,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             misalign
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        REQ  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redir_pc;
    logic            accept;

    assign fetch_addr = pc;
    assign accept     = fetch_valid & fetch_ready;
    assign pc_inc     = pc + {{(XLEN-3){1'b0}}, 3'b100};

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;
    assign misalign = misalign_q;
    assign redir_pc = redirect_target;
`else
    assign misalign = 1'b0;
    // Instructions are word aligned; drop the low bits rather than fault.
    assign redir_pc = {redirect_target[XLEN-1:2], 2'b00};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            epc         <= '0;
            fetch_cnt   <= '0;
            fetch_valid <= 1'b0;
            fetch_flush <= 1'b0;
            halted      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            fetch_flush <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
            if (state != BOOT && trap_req) begin
                // Any same-cycle accept is dropped: no PC advance, no count.
                epc         <= pc;
                pc          <= TRAP_VECTOR;
                fetch_flush <= 1'b1;
                fetch_valid <= 1'b0;
                halted      <= 1'b0;
                state       <= IDLE;
            end else if (state != BOOT && redirect_valid) begin
`ifdef PC_ALIGN_CHECK_EN
                if (|redirect_target[1:0]) begin
                    epc         <= redirect_target;
                    pc          <= TRAP_VECTOR;
                    fetch_flush <= 1'b1;
                    misalign_q  <= 1'b1;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                    state       <= IDLE;
                end else
`endif
                if (state == HALT) begin
                    // Nothing in flight while halted, so no flush is needed.
                    pc <= redir_pc;
                end else begin
                    pc          <= redir_pc;
                    fetch_flush <= 1'b1;
                    fetch_valid <= 1'b0;
                    state       <= IDLE;
                end
            end else begin
                case (state)
                    BOOT: state <= IDLE;
                    IDLE: begin
                        if (halt_req) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (!stall) begin
                            state       <= REQ;
                            fetch_valid <= 1'b1;
                        end
                    end
                    REQ: begin
                        // halt_req and stall only take effect once the request retires.
                        if (accept) begin
                            pc        <= pc_inc;
                            fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (halt_req) begin
                                state       <= HALT;
                                halted      <= 1'b1;
                                fetch_valid <= 1'b0;
                            end else if (stall) begin
                                state       <= IDLE;
                                fetch_valid <= 1'b0;
                            end
                        end
                    end
                    HALT: begin
                        if (resume) begin
                            state  <= IDLE;
                            halted <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, halt_req, resume, redirect_valid, trap_req, fetch_ready;
    logic [63:0] redirect_target;
    logic        fetch_valid, fetch_flush, halted, misalign;
    logic [63:0] fetch_addr, epc;
    logic [31:0] fetch_cnt;

    pc_seq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .halt_req       (halt_req),
        .resume         (resume),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_req       (trap_req),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_addr     (fetch_addr),
        .fetch_flush    (fetch_flush),
        .epc            (epc),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] cnt;
    } acc_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] epc;
        logic        mis;
    } flush_t;

    acc_t   acc_q[$];
    flush_t flush_q[$];
    int     tests = 0;
    int     fails = 0;
    bit     done  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_acc(input logic [63:0] a, input logic [31:0] c);
        acc_t e;
        e.addr = a;
        e.cnt  = c;
        acc_q.push_back(e);
    endtask

    task automatic push_flush(input logic [63:0] a, input logic [63:0] e, input logic m);
        flush_t f;
        f.addr = a;
        f.epc  = e;
        f.mis  = m;
        flush_q.push_back(f);
    endtask

    // Monitor: sampled mid-cycle; inputs change 2 time units after the rising edge.
    initial begin
        acc_t   ea;
        flush_t ef;
        while (!done) begin
            @(negedge clk);
            if (!rst && !trap_req && !redirect_valid && fetch_valid && fetch_ready) begin
                if (acc_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_accept: got addr %h expected no request", fetch_addr);
                end else begin
                    ea = acc_q.pop_front();
                    chk("accept_addr", fetch_addr, ea.addr);
                    chk("accept_cnt", {32'd0, fetch_cnt}, {32'd0, ea.cnt});
                end
            end
            if (fetch_flush) begin
                if (flush_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_flush: got flush at pc %h expected none", fetch_addr);
                end else begin
                    ef = flush_q.pop_front();
                    chk("flush_pc", fetch_addr, ef.addr);
                    chk("flush_epc", epc, ef.epc);
                    chk("flush_misalign", {63'd0, misalign}, {63'd0, ef.mis});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit reached;
        rst = 1'b1;
        stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
        redirect_valid = 1'b0; trap_req = 1'b0; fetch_ready = 1'b1;
        redirect_target = '0;
        step(); step();

        chk("rst_valid", {63'd0, fetch_valid}, 64'd0);
        chk("rst_addr", fetch_addr, 64'h0);
        chk("rst_epc", epc, 64'h0);
        chk("rst_cnt", {32'd0, fetch_cnt}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_flush", {63'd0, fetch_flush}, 64'd0);

        // 1: free-running fetch
        push_acc(64'h0, 32'd0);
        push_acc(64'h4, 32'd1);
        push_acc(64'h8, 32'd2);
        push_acc(64'hC, 32'd3);
        rst = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step();
            if (fetch_addr == 64'h10) reached = 1'b1;
        end
        chk("reach_0x10", {63'd0, reached}, 64'd1);

        // 2: pending request held under stall with ready low
        fetch_ready = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid", {63'd0, fetch_valid}, 64'd1);
            chk("hold_addr", fetch_addr, 64'h10);
        end
        push_acc(64'h10, 32'd4);
        fetch_ready = 1'b1;
        step();
        chk("t2_idle_valid", {63'd0, fetch_valid}, 64'd0);
        chk("t2_pc", fetch_addr, 64'h14);
        chk("t2_cnt", {32'd0, fetch_cnt}, 64'd5);

        // 3: redirect coinciding with an accept
        stall = 1'b0;
        step();
        chk("t3_req_valid", {63'd0, fetch_valid}, 64'd1);
        redirect_valid = 1'b1;
        redirect_target = 64'hAAAAAAAABBBBBBB8;
        stall = 1'b1;
        push_flush(64'hAAAAAAAABBBBBBB8, 64'h0, 1'b0);
        step();
        redirect_valid = 1'b0;
        chk("t3_cnt", {32'd0, fetch_cnt}, 64'd5);
        chk("t3_valid", {63'd0, fetch_valid}, 64'd0);
        step();
        chk("t3_flush_one_cycle", {63'd0, fetch_flush}, 64'd0);

        // 4: trap beats a simultaneous redirect
        redirect_valid = 1'b1;
        redirect_target = 64'h20;
        push_flush(64'h20, 64'h0, 1'b0);
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        step();
        chk("t4_req_addr", fetch_addr, 64'h20);
        trap_req = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 64'h9990;
        stall = 1'b1;
        push_flush(64'h100, 64'h20, 1'b0);
        step();
        trap_req = 1'b0;
        redirect_valid = 1'b0;
        chk("t4_epc", epc, 64'h20);
        chk("t4_pc", fetch_addr, 64'h100);
        chk("t4_cnt", {32'd0, fetch_cnt}, 64'd5);

        // 5: halt deferred until accept, then resume
        redirect_valid = 1'b1;
        redirect_target = 64'h40;
        push_flush(64'h40, 64'h20, 1'b0);
        step();
        redirect_valid = 1'b0;
        fetch_ready = 1'b0;
        stall = 1'b0;
        step();
        halt_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t5_hold_valid", {63'd0, fetch_valid}, 64'd1);
            chk("t5_not_halted", {63'd0, halted}, 64'd0);
            chk("t5_hold_addr", fetch_addr, 64'h40);
        end
        push_acc(64'h40, 32'd5);
        fetch_ready = 1'b1;
        step();
        chk("t5_halted", {63'd0, halted}, 64'd1);
        chk("t5_halt_valid", {63'd0, fetch_valid}, 64'd0);
        chk("t5_pc", fetch_addr, 64'h44);
        resume = 1'b1;
        stall = 1'b1;
        step();
        chk("t5_resume_wins", {63'd0, halted}, 64'd0);
        halt_req = 1'b0;
        resume = 1'b0;
        stall = 1'b0;
        push_acc(64'h44, 32'd6);
        step();
        chk("t5_refetch", fetch_addr, 64'h44);
        chk("t5_refetch_valid", {63'd0, fetch_valid}, 64'd1);
        stall = 1'b1;
        step();
        chk("t5_after_pc", fetch_addr, 64'h48);

        // redirect while halted: PC moves, no flush, stays halted
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 64'h200;
        step();
        redirect_valid = 1'b0;
        chk("halt_redir_pc", fetch_addr, 64'h200);
        chk("halt_redir_halted", {63'd0, halted}, 64'd1);
        chk("halt_redir_noflush", {63'd0, fetch_flush}, 64'd0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("halt_exit", {63'd0, halted}, 64'd0);

        // 6: PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_target = 64'hFFFFFFFFFFFFFFFC;
        push_flush(64'hFFFFFFFFFFFFFFFC, 64'h20, 1'b0);
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        push_acc(64'hFFFFFFFFFFFFFFFC, 32'd7);
        step();
        stall = 1'b1;
        step();
        chk("wrap_pc", fetch_addr, 64'h0);
        chk("wrap_cnt", {32'd0, fetch_cnt}, 64'd8);

        // misaligned redirect target
        redirect_valid = 1'b1;
        redirect_target = 64'h102;
`ifdef PC_ALIGN_CHECK_EN
        push_flush(64'h100, 64'h102, 1'b1);
`else
        push_flush(64'h100, 64'h20, 1'b0);
`endif
        step();
        redirect_valid = 1'b0;
        chk("misalign_pc", fetch_addr, 64'h100);

        // asynchronous reset in the middle of a pending request
        fetch_ready = 1'b0;
        stall = 1'b0;
        step();
        chk("pre_rst_valid", {63'd0, fetch_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, fetch_valid}, 64'd0);
        chk("async_rst_pc", fetch_addr, 64'h0);
        chk("async_rst_cnt", {32'd0, fetch_cnt}, 64'd0);
        chk("async_rst_epc", epc, 64'h0);
        step();
        rst = 1'b0;
        stall = 1'b1;
        step(); step();

        done = 1'b1;
        @(negedge clk);
        #1;
        chk("acc_queue_empty", 64'(acc_q.size()), 64'd0);
        chk("flush_queue_empty", 64'(flush_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Sequencing controller for the 64-bit program counter.
- Holds the architectural fetch PC and issues fetch requests to instruction memory over a valid/ready handshake.
- Applies redirects (branch/jump), traps, stalls and halt/resume with fixed priority.
- Sits between the decode/execute redirect logic and the instruction-fetch port; replaces the free-running PC load.

Parameters:
XLEN, 64, PC and address width
RESET_VECTOR, 64'h0000_0000_0000_0000, PC value after reset
TRAP_VECTOR, 64'h0000_0000_0000_0100, PC loaded on trap
CNT_W, 32, width of fetch counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  blocks new fetch requests
halt_req  in  1  request to enter HALT
resume  in  1  leave HALT
redirect_valid  in  1  load redirect_target as next PC
redirect_target  in  XLEN  branch/jump target
trap_req  in  1  take trap
fetch_ready  in  1  instruction memory accepts request
fetch_valid  out  1  fetch request valid
fetch_addr  out  XLEN  current PC / request address
fetch_flush  out  1  one-cycle pulse: in-flight fetches discarded
epc  out  XLEN  PC captured at last trap
halted  out  1  high in HALT state
fetch_cnt  out  CNT_W  accepted-handshake count, wraps
misalign  out  1  one-cycle pulse, misaligned redirect (optional feature only)

Behaviour:
- Reset (asserts asynchronously, effective immediately at any point, including mid-handshake):
  - state=BOOT, pc=RESET_VECTOR, epc=0, fetch_cnt=0.
  - fetch_valid=0, fetch_flush=0, halted=0, misalign=0.
- All outputs are registered; fetch_addr always equals pc.
- Handshake: accepted when fetch_valid & fetch_ready in the same cycle.
  - Once raised, fetch_valid and fetch_addr stay stable until acceptance, trap or redirect.
  - stall never withdraws an already-valid request.
- States:
  - BOOT: one cycle, then IDLE.
  - IDLE: fetch_valid=0. Goes to REQ next cycle when !stall & !halt_req; to HALT when halt_req.
  - REQ: fetch_valid=1. On accept: pc<=pc+4 and fetch_cnt+=1. Then stays in REQ if !stall & !halt_req; goes to IDLE if stall; goes to HALT if halt_req. Without accept: stays in REQ, and halt_req is deferred until accept.
  - HALT: fetch_valid=0, halted=1. resume goes to IDLE with pc unchanged.
- Per-cycle priority: rst > trap_req > redirect_valid > handshake > stall/halt.
- Trap (any state except BOOT):
  - epc<=pc, pc<=TRAP_VECTOR, fetch_flush=1 next cycle, state<=IDLE (HALT is exited).
  - A simultaneous accept is discarded: no increment, no count.
- Redirect (IDLE/REQ):
  - pc<=redirect_target, fetch_flush=1 next cycle, state<=IDLE.
  - A simultaneous accept is discarded as above.
- Redirect in HALT: pc<=target, no flush, remains halted.
- Arithmetic:
  - pc+4 wraps modulo 2^XLEN: 64'hFFFF_FFFF_FFFF_FFFC -> 0.
  - fetch_cnt wraps from 2^CNT_W-1 to 0.
- resume outside HALT is ignored. halt_req and resume together in HALT: resume wins.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: a redirect_target with bits[1:0]!=0 is treated as a trap.
  - epc<=redirect_target, pc<=TRAP_VECTOR.
  - fetch_flush and misalign pulse one cycle.
- Undefined:
  - redirect_target[1:0] is forced to 0 on load.
  - misalign is tied 0.

Test Plan:
1. Reset release, stall=0, fetch_ready=1 always -> fetch_addr 0x0, 0x4, 0x8, 0xC on successive accepts; fetch_cnt 1,2,3,4.
2. REQ at pc=0x10, fetch_ready=0 for 3 cycles with stall=1 -> fetch_valid stays 1, fetch_addr stays 0x10; ready=1 -> pc 0x14, state IDLE.
3. redirect_valid=1, target=64'hAAAAAAAABBBBBBB8, same cycle as accept -> next pc=target, fetch_flush=1 for one cycle, fetch_cnt unchanged.
4. trap_req at pc=0x20 together with redirect_valid -> epc=0x20, pc=0x100, flush pulse; redirect ignored.
5. halt_req in REQ at 0x40 with ready=0 -> stays REQ until ready; then HALT, halted=1, pc=0x44; resume -> fetch 0x44.
6. pc=64'hFFFFFFFFFFFFFFFC accepted -> pc=0. Assert rst mid-REQ -> fetch_valid=0 and pc=RESET_VECTOR immediately, before the next clock edge. With PC_ALIGN_CHECK_EN: target 0x102 -> pc=0x100, epc=0x102, misalign pulse.
